// File: rtl/uart_fifo_pkg.sv
// Shared types, defaults and helpers for the UART FIFO controller.
package uart_fifo_pkg;

  localparam int UART_FIFO_WIDTH       = 8;
  localparam int UART_FIFO_DEPTH       = 16;
  localparam int UART_FIFO_TIMEOUT_CYC = 64;

  // Level/pointer width: address bits plus one wrap bit, so 0..DEPTH fits.
  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Status bundle used when packing the FIFO flags into a register map.
  typedef struct packed {
    logic full;
    logic empty;
    logic ovf;
    logic udf;
    logic thresh_irq;
    logic timeout;
  } uart_fifo_status_t;

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Push/pop data bus between the UART shifter side and the register side.
interface uart_fifo_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic             re;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;

  // Requester: issues writes/reads, receives popped data.
  modport master (
    output we, wdata, re,
    input  rdata, rvalid
  );

  // FIFO: accepts requests, returns popped data.
  modport slave (
    input  we, wdata, re,
    output rdata, rvalid
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is not reset so it can map onto block/distributed RAM;
// only the output register is reset.
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Write port: store the word at the write address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Next read data: a read fetches the slot's pre-write contents, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem[raddr_i];
    end
  end

  // Registered read output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART RX/TX FIFO controller: pointer/level tracking, simultaneous push+pop,
// level threshold interrupt, sticky overflow/underflow, flush, RX timeout.
module uart_fifo_ctrl
  import uart_fifo_pkg::*;
#(
  parameter int  WIDTH       = UART_FIFO_WIDTH,
  parameter int  DEPTH       = UART_FIFO_DEPTH,
  parameter int  TIMEOUT_CYC = UART_FIFO_TIMEOUT_CYC,
  localparam int LVL_W       = fifo_lvl_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  uart_fifo_ctrl_if.slave   bus,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o,
  input  logic [LVL_W-1:0]  thresh_i,
  output logic              thresh_irq_o,
  output logic              timeout_o,
  output logic              ovf_o,
  output logic              udf_o,
  input  logic              clr_err_i
);

  localparam int AW = LVL_W - 1;

  logic [LVL_W-1:0] wptr_q, wptr_d;
  logic [LVL_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level;
  logic             empty, full;
  logic             push, pop;
  logic             rvalid_q, rvalid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] rdata;

  // Occupancy and flags straight from the registered pointers.
  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push
  // alongside it. Flush drops both requests.
  assign pop  = bus.re & ~empty & ~flush_i;
  assign push = bus.we & (~full | pop) & ~flush_i;

  // Next pointer values: flush rewinds both, otherwise advance on accept.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + LVL_W'(1);
      if (pop)  rptr_d = rptr_q + LVL_W'(1);
    end
  end

  // Next read-valid and sticky error flags; a new error beats a clear.
  always_comb begin
    rvalid_d = pop;
    ovf_d    = (bus.we & full & ~pop & ~flush_i) | (ovf_q & ~clr_err_i);
    udf_d    = (bus.re & empty & ~flush_i) | (udf_q & ~clr_err_i);
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (push),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (bus.wdata),
    .re_i    (pop),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  // Character timeout: counts idle cycles while data sits unread.
  if (TIMEOUT_CYC > 0) begin : g_timeout
    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Restart on any activity or when empty, otherwise count up and saturate.
    always_comb begin
      cnt_d = cnt_q;
      if (push || pop || flush_i || empty) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Idle counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign timeout_o = (cnt_q == CNT_MAX) & ~empty;
  end else begin : g_no_timeout
    assign timeout_o = 1'b0;
  end

  assign bus.rdata    = rdata;
  assign bus.rvalid   = rvalid_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign level_o      = level;
  assign thresh_irq_o = (thresh_i != '0) && (level >= thresh_i);
  assign ovf_o        = ovf_q;
  assign udf_o        = udf_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: queue-based reference model plus a read-data
// scoreboard drained by an independent monitor.
module tb_uart_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       clr_err;
  logic [4:0] thresh;
  logic       full, empty, thresh_irq, timeout, ovf, udf;
  logic [4:0] level;

  uart_fifo_ctrl_if #(.WIDTH(8)) bus ();

  uart_fifo_ctrl #(
    .WIDTH       (8),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .bus          (bus),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
    .thresh_i     (thresh),
    .thresh_irq_o (thresh_irq),
    .timeout_o    (timeout),
    .ovf_o        (ovf),
    .udf_o        (udf),
    .clr_err_i    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] mq[$];
  logic [7:0] sbq[$];
  bit         m_ovf = 0;
  bit         m_udf = 0;
  int         idle  = 0;
  int         thr   = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Model-side expectations after each clock.
  task automatic check_flags(input bit exp_rvalid);
    int sz;
    sz = mq.size();
    chk("level", int'(level), sz);
    chk("full", int'(full), int'(sz == DEPTH));
    chk("empty", int'(empty), int'(sz == 0));
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("udf", int'(udf), int'(m_udf));
    chk("thresh_irq", int'(thresh_irq), int'(thr != 0 && sz >= thr));
    chk("timeout", int'(timeout), int'(idle == TO && sz != 0));
    chk("rvalid", int'(bus.rvalid), int'(exp_rvalid));
  endtask

  // One clock of stimulus; the model decides acceptance from the queue state.
  task automatic step(input bit we, input logic [7:0] wd, input bit re,
                      input bit fl, input bit clr);
    bit was_full, was_empty, pop, push, oset, uset;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    bus.we  = we;
    bus.wdata = wd;
    bus.re  = re;
    flush   = fl;
    clr_err = clr;
    thresh  = 5'(thr);
    pop = 0; push = 0; oset = 0; uset = 0;
    if (fl) begin
      mq.delete();
      idle = 0;
    end else begin
      pop  = re && !was_empty;
      push = we && (!was_full || pop);
      oset = we && was_full && !pop;
      uset = re && was_empty;
      if (pop)  sbq.push_back(mq.pop_front());
      if (push) mq.push_back(wd);
      if (push || pop || was_empty) idle = 0;
      else if (idle < TO) idle++;
    end
    m_ovf = oset || (m_ovf && !clr);
    m_udf = uset || (m_udf && !clr);
    @(posedge clk);
    #1;
    check_flags(pop);
  endtask

  task automatic idle_step();
    step(0, 8'h00, 0, 0, 0);
  endtask

  // Monitor: every presented read word must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.rvalid) begin
      if (sbq.size() == 0) begin
        chk("rvalid_unexpected", 1, 0);
      end else begin
        chk("rdata", int'(bus.rdata), int'(sbq.pop_front()));
      end
    end
  end

  logic [7:0] d;

  initial begin
    rst_n = 1'b0; flush = 0; clr_err = 0; thresh = 0;
    bus.we = 0; bus.wdata = 0; bus.re = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", int'(bus.rdata), 0);
    check_flags(0);
    rst_n = 1'b1;

    // Fill to full, overflow attempt, drain in order.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    idle_step();
    step(0, 8'h00, 0, 0, 1);

    // Full FIFO with continuous push+pop across pointer wraps.
    d = 8'h40;
    for (int i = 0; i < 16; i++) begin step(1, d, 0, 0, 0); d++; end
    for (int i = 0; i < 40; i++) begin step(1, d, 1, 0, 0); d++; end
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    idle_step();

    // Empty boundary: simultaneous request only pushes, flags underflow.
    step(1, 8'hA5, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Threshold and idle timeout.
    thr = 4;
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    for (int i = 0; i < TO + 2; i++) idle_step();
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
    idle_step();

    // Flush wins over a coincident write.
    for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    step(1, 8'h77, 0, 1, 0);
    step(1, 8'h3C, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    idle_step();

    // Async reset between edges at level 7 with sticky underflow set.
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
    idle_step();
    #3;
    rst_n = 1'b0;
    mq.delete();
    m_ovf = 0; m_udf = 0; idle = 0;
    #1;
    chk("async_rst_rdata", int'(bus.rdata), 0);
    check_flags(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 8'h11, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    idle_step();

    // Randomized traffic with occasional idle bursts.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) thr = $urandom_range(0, 16);
      if ($urandom_range(0, 49) == 0) begin
        for (int k = 0; k < TO + 3; k++) idle_step();
      end
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6);
    end
    idle_step();
    idle_step();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
